// File: rtl/pong_game_ctrl.sv
// Pong game controller: button synchronizers, game tick divider, paddle and ball motion,
// collision and scoring, and a four-state game FSM with 7-segment score decoding.
module pong_game_ctrl #(
  parameter int HBP         = 144,
  parameter int VBP         = 31,
  parameter int TICK_DIV    = 416667,
  parameter int PAUSE_TICKS = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  input  logic       serve,
  output logic [9:0] ballx,
  output logic [9:0] bally,
  output logic [9:0] l_pos,
  output logic [9:0] r_pos,
  output logic [6:0] score_l,
  output logic [6:0] score_r,
  output logic       game_over
);

  localparam int CNT_W  = $clog2(TICK_DIV + 1);
  localparam int PCNT_W = $clog2(PAUSE_TICKS + 1);

  localparam logic [9:0] X_CTR   = 10'(HBP + 320);
  localparam logic [9:0] Y_CTR   = 10'(VBP + 240);
  localparam logic [9:0] X_LHIT  = 10'(HBP + 75);
  localparam logic [9:0] X_RHIT  = 10'(HBP + 569);
  localparam logic [9:0] X_LMISS = 10'(HBP + 55);
  localparam logic [9:0] X_RMISS = 10'(HBP + 584);
  localparam logic [9:0] Y_TOP   = 10'(VBP + 54);
  localparam logic [9:0] Y_BOT   = 10'(VBP + 424);
  localparam logic [9:0] P_MIN   = 10'(VBP + 50);
  localparam logic [9:0] P_MAX   = 10'(VBP + 330);
  localparam logic [9:0] P_RESET = 10'(VBP + 190);
  localparam logic [3:0] WIN4    = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [PCNT_W-1:0] PAUSE_LAST = PCNT_W'(PAUSE_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, POINT, GAMEOVER} state_t;

  state_t              state_q, state_n;
  logic [4:0]          sync1, sync2;  // {serve, r_dn, r_up, l_dn, l_up}
  logic                serve_prev, serve_pend, serve_rise;
  logic [CNT_W-1:0]    div_cnt;
  logic                tick;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_n;
  logic                dx_neg, dy_neg, dx_n, dy_n;
  logic [9:0]          ballx_n, bally_n, l_pos_n, r_pos_n;
  logic [3:0]          score_l_q, score_r_q, score_l_n, score_r_n;
  logic                miss_l, miss_r, hit_l, hit_r, bounce_y;

  function automatic logic [9:0] paddle_step(input logic [9:0] pos, input logic up, input logic dn);
    paddle_step = pos;
    if (up && !dn)      paddle_step = (pos <= P_MIN + 10'd2) ? P_MIN : pos - 10'd2;
    else if (dn && !up) paddle_step = (pos >= P_MAX - 10'd2) ? P_MAX : pos + 10'd2;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign tick       = (div_cnt == DIV_LAST);
  assign serve_rise = sync2[4] && !serve_prev;
  assign miss_l     = dx_neg && (ballx == X_LMISS);
  assign miss_r     = !dx_neg && (ballx == X_RMISS);
  assign hit_l      = dx_neg && (ballx == X_LHIT) && (bally >= l_pos) && (bally <= l_pos + 10'd99);
  assign hit_r      = !dx_neg && (ballx == X_RHIT) && (bally >= r_pos) && (bally <= r_pos + 10'd99);
  assign bounce_y   = (dy_neg && bally == Y_TOP) || (!dy_neg && bally == Y_BOT);
  assign score_l    = seg7(score_l_q);
  assign score_r    = seg7(score_r_q);
  assign game_over  = (state_q == GAMEOVER);

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_n   = state_q;
    ballx_n   = ballx;
    bally_n   = bally;
    dx_n      = dx_neg;
    dy_n      = dy_neg;
    l_pos_n   = l_pos;
    r_pos_n   = r_pos;
    score_l_n = score_l_q;
    score_r_n = score_r_q;
    pcnt_n    = pcnt_q;
    if (tick) begin
      if (state_q != GAMEOVER) begin
        l_pos_n = paddle_step(l_pos, sync2[0], sync2[1]);
        r_pos_n = paddle_step(r_pos, sync2[2], sync2[3]);
      end
      unique case (state_q)
        IDLE: if (serve_pend) state_n = PLAY;
        PLAY: begin
          if (miss_l) begin
            score_r_n = score_r_q + 4'd1;
            state_n   = (score_r_n == WIN4) ? GAMEOVER : POINT;
            pcnt_n    = '0;
          end else if (miss_r) begin
            score_l_n = score_l_q + 4'd1;
            state_n   = (score_l_n == WIN4) ? GAMEOVER : POINT;
            pcnt_n    = '0;
          end else begin
            // X and Y rules are independent, so a corner applies both on one tick.
            if (bounce_y) dy_n = !dy_neg;
            bally_n = dy_n ? bally - 10'd1 : bally + 10'd1;
            if (hit_l || hit_r) dx_n = !dx_neg;
            ballx_n = dx_n ? ballx - 10'd1 : ballx + 10'd1;
          end
        end
        POINT: begin
          // dx still points at the conceding player, so serving toward them needs no update.
          if (pcnt_q == PAUSE_LAST) begin
            state_n = IDLE;
            pcnt_n  = '0;
            ballx_n = X_CTR;
            bally_n = Y_CTR;
          end else begin
            pcnt_n = pcnt_q + PCNT_W'(1);
          end
        end
        GAMEOVER: if (serve_pend) begin
          state_n   = IDLE;
          score_l_n = 4'd0;
          score_r_n = 4'd0;
          ballx_n   = X_CTR;
          bally_n   = Y_CTR;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge dclk) begin
    if (clr) begin
      sync1      <= '0;
      sync2      <= '0;
      serve_prev <= 1'b0;
      serve_pend <= 1'b0;
      div_cnt    <= '0;
      state_q    <= IDLE;
      pcnt_q     <= '0;
      ballx      <= X_CTR;
      bally      <= Y_CTR;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      l_pos      <= P_RESET;
      r_pos      <= P_RESET;
      score_l_q  <= 4'd0;
      score_r_q  <= 4'd0;
    end else begin
      sync1      <= {serve, r_dn, r_up, l_dn, l_up};
      sync2      <= sync1;
      serve_prev <= sync2[4];
      // Any tick consumes or discards a pending serve; a fresh edge always registers.
      serve_pend <= (serve_pend && !tick) || serve_rise;
      div_cnt    <= tick ? '0 : div_cnt + CNT_W'(1);
      state_q    <= state_n;
      pcnt_q     <= pcnt_n;
      ballx      <= ballx_n;
      bally      <= bally_n;
      dx_neg     <= dx_n;
      dy_neg     <= dy_n;
      l_pos      <= l_pos_n;
      r_pos      <= r_pos_n;
      score_l_q  <= score_l_n;
      score_r_q  <= score_r_n;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a 4-cycle tick and a 3-tick pause;
// expected coordinates are hand-derived from the ball trajectory.
module tb_pong_game_ctrl;

  logic       dclk, clr, l_up, l_dn, r_up, r_dn, serve;
  logic [9:0] ballx, bally, l_pos, r_pos;
  logic [6:0] score_l, score_r;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  pong_game_ctrl #(
    .HBP(144), .VBP(31), .TICK_DIV(4), .PAUSE_TICKS(3), .WIN_SCORE(9)
  ) dut (
    .dclk(dclk), .clr(clr), .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn),
    .serve(serve), .ballx(ballx), .bally(bally), .l_pos(l_pos), .r_pos(r_pos),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance n game ticks and land 1 ns after the last tick edge.
  task automatic ticks(input int n);
    repeat (4 * n) @(posedge dclk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(posedge dclk);
    #1;
    clr = 1'b0;
  endtask

  task automatic press_serve();
    serve = 1'b1;
    ticks(1);
    serve = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ballx"}, 32'(ballx), 32'd464);
    check({tag, "_bally"}, 32'(bally), 32'd271);
    check({tag, "_l_pos"}, 32'(l_pos), 32'd221);
    check({tag, "_r_pos"}, 32'(r_pos), 32'd221);
    check({tag, "_score_l"}, 32'(score_l), 32'(seg[0]));
    check({tag, "_score_r"}, 32'(score_r), 32'(seg[0]));
    check({tag, "_game_over"}, 32'(game_over), 32'd0);
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(ballx), 32'(x));
    check({tag, "_y"}, 32'(bally), 32'(y));
  endtask

  initial begin
    {l_up, l_dn, r_up, r_dn, serve} = '0;
    do_reset();
    check_reset_state("rst");
    ticks(5);
    check_reset_state("idle_hold");

    // Paddle stepping, clamping and opposing buttons (all in IDLE).
    l_up = 1'b1;
    ticks(1);
    check("l_up_step", 32'(l_pos), 32'd219);
    ticks(69);
    check("l_up_clamp", 32'(l_pos), 32'd81);
    ticks(5);
    check("l_up_held", 32'(l_pos), 32'd81);
    l_dn = 1'b1;
    ticks(3);
    check("l_both", 32'(l_pos), 32'd81);
    l_up = 1'b0;
    ticks(2);
    check("l_dn_step", 32'(l_pos), 32'd85);
    l_dn = 1'b0;
    r_dn = 1'b1;
    ticks(80);
    check("r_dn_clamp", 32'(r_pos), 32'd361);
    r_dn = 1'b0;
    check_ball("idle_ball", 464, 271);

    // Run A: right paddle returns the ball, left paddle catches it on its bottom line.
    do_reset();
    l_up = 1'b1; r_dn = 1'b1;
    ticks(23);
    l_up = 1'b0;
    ticks(27);
    r_dn = 1'b0;
    check("a_l_pos", 32'(l_pos), 32'd175);
    check("a_r_pos", 32'(r_pos), 32'd321);
    press_serve();
    check_ball("a_serve", 464, 271);
    ticks(1);
    check_ball("a_t1", 465, 272);
    ticks(183);
    check_ball("a_t184", 648, 455);
    ticks(1);
    check_ball("a_bounce_bot", 649, 454);
    ticks(64);
    check_ball("a_t249", 713, 390);
    ticks(1);
    check_ball("a_hit_r", 712, 389);
    ticks(304);
    check_ball("a_t554", 408, 85);
    ticks(1);
    check_ball("a_bounce_top", 407, 86);
    ticks(188);
    check_ball("a_t743", 219, 274);
    ticks(1);
    check_ball("a_hit_l_edge", 220, 275);

    // Run B: left paddle one line below the ball, so the ball passes and scores for the right.
    do_reset();
    l_dn = 1'b1; r_dn = 1'b1;
    ticks(27);
    l_dn = 1'b0;
    ticks(23);
    r_dn = 1'b0;
    check("b_l_pos", 32'(l_pos), 32'd275);
    press_serve();
    ticks(743);
    check_ball("b_t743", 219, 274);
    ticks(20);
    check_ball("b_t763", 199, 294);
    check("b_score_r_pre", 32'(score_r), 32'(seg[0]));
    ticks(1);
    check_ball("b_miss_frozen", 199, 294);
    check("b_score_r", 32'(score_r), 32'(seg[1]));
    check("b_game_over", 32'(game_over), 32'd0);
    ticks(1);
    check_ball("b_point_frozen", 199, 294);
    do_reset();
    check_reset_state("mid_point_clr");

    // Run C: the right paddle never moves, so the right player concedes every point.
    for (int k = 1; k <= 9; k++) begin
      press_serve();
      ticks(264);
      check("c_pre_miss_x", 32'(ballx), 32'd728);
      check("c_pre_miss_score", 32'(score_l), 32'(seg[k-1]));
      ticks(1);
      check("c_miss_x", 32'(ballx), 32'd728);
      check("c_score_l", 32'(score_l), 32'(seg[k]));
      check("c_score_r", 32'(score_r), 32'(seg[0]));
      if (k < 9) begin
        check("c_game_over_lo", 32'(game_over), 32'd0);
        ticks(2);
        check("c_pause_frozen", 32'(ballx), 32'd728);
        ticks(1);
        check_ball("c_recentre", 464, 271);
      end
    end
    check("c_game_over", 32'(game_over), 32'd1);
    r_up = 1'b1;
    ticks(2);
    check("c_gameover_paddle", 32'(r_pos), 32'd221);
    r_up = 1'b0;
    check("c_gameover_hold", 32'(game_over), 32'd1);
    press_serve();
    check("c_restart_go", 32'(game_over), 32'd0);
    check("c_restart_l", 32'(score_l), 32'(seg[0]));
    check("c_restart_r", 32'(score_r), 32'(seg[0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter HBP, default 144, horizontal back-porch offset added to every x coordinate.
REQ-002 Parameter VBP, default 31, vertical back-porch offset added to every y coordinate.
REQ-003 Parameter TICK_DIV, default 416667, dclk cycles per game tick (60 Hz at 25 MHz).
REQ-004 Parameter PAUSE_TICKS, default 60, ticks the ball stays frozen after a point.
REQ-005 Parameter WIN_SCORE, default 9, score that ends the game (range 1..9).
REQ-006 dclk  in  1  pixel clock; the block's only clock.
REQ-007 clr  in  1  reset, synchronous to dclk, active-high.
REQ-008 l_up, l_dn, r_up, r_dn  in  1 each  asynchronous paddle buttons, active-high.
REQ-009 serve  in  1  asynchronous serve/restart button, active-high.
REQ-010 ballx, bally  out  10 each  ball centre in raw hc/vc counter coordinates; ball drawn over (c-5, c+5].
REQ-011 l_pos, r_pos  out  10 each  paddle top line in vc coordinates; paddle is 100 lines tall.
REQ-012 score_l, score_r  out  7 each  active-high segment patterns: bit0 top, 1 top-right, 2 bottom-right, 3 bottom, 4 bottom-left, 5 top-left, 6 middle.
REQ-013 game_over  out  1  high while in state GAMEOVER.

Function
REQ-014 All buttons SHALL pass through a 2-flop synchronizer before use.
REQ-015 A divider SHALL pulse tick for one cycle when its count equals TICK_DIV-1, then wrap to 0; all positions, scores and state SHALL change only on tick cycles, with outputs registered and visible the cycle after tick.
REQ-016 A synchronized rising edge of serve SHALL set serve_pend; the flag SHALL clear when consumed on a tick in IDLE or GAMEOVER and SHALL be discarded on any tick in PLAY or POINT.
REQ-017 States: IDLE, PLAY, POINT, GAMEOVER. IDLE + tick + serve_pend -> PLAY; PLAY + miss -> POINT, or GAMEOVER if the incremented score equals WIN_SCORE; POINT after PAUSE_TICKS ticks -> IDLE; GAMEOVER + tick + serve_pend -> IDLE with both scores cleared.
REQ-018 Paddles SHALL move 2 lines per tick in every state except GAMEOVER: up-only decrements, down-only increments, both or neither holds, clamped to [VBP+50, VBP+330].
REQ-019 In PLAY, the ball SHALL move 1 pixel per tick on each axis by dx, dy (each +/-1).
REQ-020 Vertical bounce: dy=-1 at bally=VBP+54, or dy=+1 at bally=VBP+424, SHALL negate dy and move by the new dy on the same tick.
REQ-021 Left hit: dx=-1, ballx=HBP+75 and l_pos <= bally <= l_pos+99 SHALL negate dx and move by the new dx. Right hit: dx=+1, ballx=HBP+569, r_pos range, same response.
REQ-022 Collision tests SHALL use paddle values registered before the current tick; corner cases apply the X and Y rules independently on the same tick.
REQ-023 Left miss: dx=-1 and ballx=HBP+55 SHALL give score_r+1. Right miss: dx=+1 and ballx=HBP+584 SHALL give score_l+1. The ball SHALL freeze at the miss position.
REQ-024 On POINT -> IDLE, the ball SHALL recentre to (HBP+320, VBP+240), dx SHALL point toward the player who conceded, and dy SHALL be kept.
REQ-025 Scores SHALL be held internally as 4-bit binary 0..WIN_SCORE and decoded to standard 7-segment patterns (0=0111111, 1=0000110, ..., 9=1101111).

Reset
REQ-026 With clr high at a dclk edge, the block SHALL set: state IDLE, divider 0, serve_pend 0, pause counter 0, ballx=HBP+320, bally=VBP+240, dx=+1, dy=+1, l_pos=r_pos=VBP+190, scores 0 (patterns 0111111), game_over 0, synchronizers 0.
REQ-027 clr in any state, including mid-POINT or GAMEOVER, SHALL take priority over tick and all buttons.

Verification
REQ-028 Reset, then TICK_DIV=4 with no buttons -> outputs hold at reset values (464, 271, 221, 221, 0111111) indefinitely.
REQ-029 serve pulse in IDLE -> PLAY at next tick; after 1 more tick ballx=465, bally=272.
REQ-030 l_up held 200 ticks -> l_pos steps 221, 219, ... and clamps at 81; l_up and l_dn together -> no movement.
REQ-031 Ball at ballx=219 (HBP+75), dx=-1, bally=l_pos+99 -> dx becomes +1, ballx=220; with bally=l_pos+100 -> ball continues to 199, POINT, score_r=0000110.
REQ-032 score_l=8 and right miss -> GAMEOVER, game_over=1, score_l=1101111; serve -> IDLE with scores 0111111.
REQ-033 clr asserted mid-POINT -> next cycle all outputs equal REQ-026 values; pause counter restarts on the next point.
